pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It merges four hazard sources into one consistent set of pipeline-register enables and bubble controls: load-use, taken-branch redirect, multi-cycle data-memory wait, and halt on a retiring ecall. It sits beside the datapath and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls. It keeps saturating stall and flush counters for performance debug.

Parameters:
MAX_WAIT, 16, data-memory wait cycles tolerated before timeout (1..255)
CNT_W, 32, width of the stall and flush counters

Ports:
CLK  in  1  rising-edge clock
RSTn  in  1  reset; synchronous, active-low
memRead_EX  in  1  instruction in EX is a load
RD_EX  in  5  destination register of the EX instruction
RS1_ID  in  5  rs1 of the ID instruction
RS2_ID  in  5  rs2 of the ID instruction
useRS1_ID  in  1  ID instruction reads rs1
useRS2_ID  in  1  ID instruction reads rs2
branchTaken_EX  in  1  EX resolved a taken branch or jump (PC redirect)
memReq_MEM  in  1  MEM stage is issuing a data-memory access
memReady  in  1  data memory has completed the access this cycle
haltReq_WB  in  1  ecall/halt instruction is retiring in WB
pcWrite  out  1  PC update enable
IF_ID_WE  out  1  IF/ID write enable
ID_EX_WE  out  1  ID/EX write enable
EX_MEM_WE  out  1  EX/MEM write enable
MEM_WB_WE  out  1  MEM/WB write enable
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_nop  out  1  load bubble into ID/EX
MEM_WB_nop  out  1  load bubble into MEM/WB
halted  out  1  registered; 1 in HALT
memError  out  1  registered sticky; data-memory timeout
stallCount  out  CNT_W  cycles with pcWrite=0 while not halted, saturating
flushCount  out  CNT_W  cycles with IF_ID_flush=1, saturating

Behaviour:
- States: RUN, MEM_WAIT, HALT. waitCnt is 8 bits.
- Reset: RSTn=0 at posedge gives state=RUN, waitCnt=0, halted=0, memError=0, both counters=0. While RSTn=0, the combinational outputs are forced to: pcWrite=0, all WE=0, IF_ID_flush=1, ID_EX_nop=1, MEM_WB_nop=1. Reset mid-wait or in HALT behaves identically.
- Derived signals:
  - memStall = memReq_MEM & ~memReady
  - loadUse = memRead_EX & (RD_EX!=0) & ((useRS1_ID & RS1_ID==RD_EX) | (useRS2_ID & RS2_ID==RD_EX))
- Default outputs (normal): all enables 1, all flush/nop 0.
- Priority, evaluated in RUN and MEM_WAIT every cycle, highest first:
  1. haltReq_WB: pcWrite=0, all WE=0. Next state is HALT.
  2. memStall: pcWrite=0, IF_ID_WE=ID_EX_WE=EX_MEM_WE=0, MEM_WB_WE=1 with MEM_WB_nop=1. Next state is MEM_WAIT and waitCnt increments.
  3. branchTaken_EX: pcWrite=1, all WE=1, IF_ID_flush=1, ID_EX_nop=1. loadUse is ignored because the ID instruction is squashed.
  4. loadUse: pcWrite=0, IF_ID_WE=0, ID_EX_nop=1, other WE=1. Exactly one bubble per load; the next cycle the load is in MEM and loadUse is false.
  5. Otherwise, normal outputs.
- RUN: memStall moves to MEM_WAIT with waitCnt=1.
- MEM_WAIT:
  - memReady=1: this cycle uses rules 3–5 (access completes). Next state is RUN and waitCnt=0.
  - memStall with waitCnt==MAX_WAIT: next state is HALT and memError is set to 1.
  - Outputs on the timeout cycle are the memStall outputs.
  - haltReq_WB still wins in MEM_WAIT.
- HALT: absorbing until reset. pcWrite=0, all WE=0, flush/nop=0, halted=1.
- Counters:
  - stallCount increments on each RUN/MEM_WAIT cycle with pcWrite=0, including the halt-entry cycle.
  - flushCount increments when IF_ID_flush=1 outside reset.
  - Both saturate at all-ones and do not wrap. Both hold in HALT.

Test Plan:
- Load x5 in EX (memRead_EX=1, RD_EX=5), ID reads rs2=5 with useRS2_ID=1 -> one cycle of pcWrite=0, IF_ID_WE=0, ID_EX_nop=1; next cycle normal; stallCount=1.
- RD_EX=0 with a matching RS1; or a match with useRS1_ID=0 -> no stall.
- Load-use and branchTaken_EX in the same cycle -> IF_ID_flush=1, ID_EX_nop=1, pcWrite=1; flushCount=1, stallCount=0.
- memReq_MEM=1, memReady low for 3 cycles then high -> 3 cycles frozen with MEM_WB_nop=1, state MEM_WAIT; release on the 4th cycle; state RUN; stallCount=3.
- memReady never asserted, MAX_WAIT=4 -> after 5 stall cycles, halted=1 and memError=1; all WE stay 0 thereafter.
- haltReq_WB pulse -> halted=1 next cycle; inputs ignored afterwards. RSTn=0 for 1 cycle -> RUN, counters 0, halted=0, memError=0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It merges the load-use, branch-redirect, data-memory-wait and halt hazards
// into one set of pipeline-register enables and bubble controls.
// It also keeps saturating stall and flush counters for performance debug.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_RUN      | normal issue; hazards resolved cycle by cycle
//   ST_MEM_WAIT | data-memory access outstanding; waitCnt counts stall cycles
//   ST_HALT     | retired ecall or memory timeout; frozen until reset
module pipeline_hazard_controller #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             memRead_EX,
   input  logic [4:0]       RD_EX,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic             useRS1_ID,
   input  logic             useRS2_ID,
   input  logic             branchTaken_EX,
   input  logic             memReq_MEM,
   input  logic             memReady,
   input  logic             haltReq_WB,
   output logic             pcWrite,
   output logic             IF_ID_WE,
   output logic             ID_EX_WE,
   output logic             EX_MEM_WE,
   output logic             MEM_WB_WE,
   output logic             IF_ID_flush,
   output logic             ID_EX_nop,
   output logic             MEM_WB_nop,
   output logic             halted,
   output logic             memError,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT     = 2'd2;

   localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);

   logic [1:0]       state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_error_q, mem_error_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic mem_stall;
   logic load_use;

   assign mem_stall = memReq_MEM & ~memReady;
   assign load_use  = memRead_EX & (RD_EX != 5'd0) &
                      ((useRS1_ID & (RS1_ID == RD_EX)) |
                       (useRS2_ID & (RS2_ID == RD_EX)));

   // Hazard priority resolution: pipeline controls and next FSM state
   always_comb begin
      pcWrite     = 1'b1;
      IF_ID_WE    = 1'b1;
      ID_EX_WE    = 1'b1;
      EX_MEM_WE   = 1'b1;
      MEM_WB_WE   = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_nop   = 1'b0;
      MEM_WB_nop  = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_error_d = mem_error_q;

      if (!RSTn) begin
         // Hold every stage and fill the pipe with bubbles while in reset
         pcWrite     = 1'b0;
         IF_ID_WE    = 1'b0;
         ID_EX_WE    = 1'b0;
         EX_MEM_WE   = 1'b0;
         MEM_WB_WE   = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_nop   = 1'b1;
         MEM_WB_nop  = 1'b1;
      end else if (state_q == ST_HALT) begin
         pcWrite   = 1'b0;
         IF_ID_WE  = 1'b0;
         ID_EX_WE  = 1'b0;
         EX_MEM_WE = 1'b0;
         MEM_WB_WE = 1'b0;
      end else if (haltReq_WB) begin
         pcWrite   = 1'b0;
         IF_ID_WE  = 1'b0;
         ID_EX_WE  = 1'b0;
         EX_MEM_WE = 1'b0;
         MEM_WB_WE = 1'b0;
         state_d   = ST_HALT;
      end else if (mem_stall) begin
         // Freeze the front of the pipe; WB drains and takes a bubble
         pcWrite    = 1'b0;
         IF_ID_WE   = 1'b0;
         ID_EX_WE   = 1'b0;
         EX_MEM_WE  = 1'b0;
         MEM_WB_nop = 1'b1;
         if ((state_q == ST_MEM_WAIT) && (wait_cnt_q == MAX_WAIT_C)) begin
            state_d     = ST_HALT;
            mem_error_d = 1'b1;
         end else begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end else begin
         state_d    = ST_RUN;
         wait_cnt_d = 8'd0;
         if (branchTaken_EX) begin
            // The ID instruction is squashed, so any load-use on it is moot
            IF_ID_flush = 1'b1;
            ID_EX_nop   = 1'b1;
         end else if (load_use) begin
            pcWrite   = 1'b0;
            IF_ID_WE  = 1'b0;
            ID_EX_nop = 1'b1;
         end
      end
   end

   // Saturating performance counters; neither advances in reset or HALT
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (RSTn && (state_q != ST_HALT) && !pcWrite && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (RSTn && IF_ID_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // State and counter registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= 8'd0;
         mem_error_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_error_q <= mem_error_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halted     = (state_q == ST_HALT);
   assign memError   = mem_error_q;
   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MAX_WAIT=4, 3-bit counters).
module tb_pipeline_hazard_controller;

   localparam int CW = 3;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          memRead_EX;
   logic [4:0]    RD_EX, RS1_ID, RS2_ID;
   logic          useRS1_ID, useRS2_ID;
   logic          branchTaken_EX, memReq_MEM, memReady, haltReq_WB;
   logic          pcWrite, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE;
   logic          IF_ID_flush, ID_EX_nop, MEM_WB_nop, halted, memError;
   logic [CW-1:0] stallCount, flushCount;
   logic [7:0]    ctl;

   int checks = 0;
   int errors = 0;

   // {pcWrite, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE, IF_ID_flush, ID_EX_nop, MEM_WB_nop}
   localparam logic [7:0] C_NORMAL = 8'b11111_000;
   localparam logic [7:0] C_RESET  = 8'b00000_111;
   localparam logic [7:0] C_FROZEN = 8'b00000_000;
   localparam logic [7:0] C_MEMST  = 8'b00001_001;
   localparam logic [7:0] C_BRANCH = 8'b11111_110;
   localparam logic [7:0] C_LU     = 8'b00111_010;

   assign ctl = {pcWrite, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE,
                 IF_ID_flush, ID_EX_nop, MEM_WB_nop};

   pipeline_hazard_controller #(.MAX_WAIT(4), .CNT_W(CW)) dut (
      .CLK(CLK), .RSTn(RSTn), .memRead_EX(memRead_EX), .RD_EX(RD_EX),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .useRS1_ID(useRS1_ID),
      .useRS2_ID(useRS2_ID), .branchTaken_EX(branchTaken_EX),
      .memReq_MEM(memReq_MEM), .memReady(memReady), .haltReq_WB(haltReq_WB),
      .pcWrite(pcWrite), .IF_ID_WE(IF_ID_WE), .ID_EX_WE(ID_EX_WE),
      .EX_MEM_WE(EX_MEM_WE), .MEM_WB_WE(MEM_WB_WE), .IF_ID_flush(IF_ID_flush),
      .ID_EX_nop(ID_EX_nop), .MEM_WB_nop(MEM_WB_nop), .halted(halted),
      .memError(memError), .stallCount(stallCount), .flushCount(flushCount)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      memRead_EX = 0; RD_EX = 0; RS1_ID = 0; RS2_ID = 0;
      useRS1_ID = 0; useRS2_ID = 0; branchTaken_EX = 0;
      memReq_MEM = 0; memReady = 0; haltReq_WB = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RSTn = 0;
      cyc();
      RSTn = 1;
   endtask

   task automatic chk_regs(input string tag, input logic h, input logic e,
                           input int sc, input int fc);
      chk({tag, "_halted"}, 32'(halted), 32'(h));
      chk({tag, "_memError"}, 32'(memError), 32'(e));
      chk({tag, "_stallCount"}, 32'(stallCount), 32'(sc));
      chk({tag, "_flushCount"}, 32'(flushCount), 32'(fc));
   endtask

   initial begin
      idle_inputs();
      RSTn = 0;
      #1 chk("reset_ctl", 32'(ctl), 32'(C_RESET));
      cyc();
      chk_regs("reset", 0, 0, 0, 0);

      // load-use through rs2: exactly one bubble
      RSTn = 1;
      #1 chk("run_idle_ctl", 32'(ctl), 32'(C_NORMAL));
      memRead_EX = 1; RD_EX = 5; RS2_ID = 5; useRS2_ID = 1;
      #1 chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
      cyc();
      idle_inputs();
      #1 chk("lu_after_ctl", 32'(ctl), 32'(C_NORMAL));
      chk_regs("lu", 0, 0, 1, 0);

      // no stall on x0 or on an unused source
      memRead_EX = 1; RD_EX = 0; RS1_ID = 0; useRS1_ID = 1;
      #1 chk("lu_x0_ctl", 32'(ctl), 32'(C_NORMAL));
      RD_EX = 7; RS1_ID = 7; useRS1_ID = 0;
      #1 chk("lu_unused_ctl", 32'(ctl), 32'(C_NORMAL));
      useRS1_ID = 1;
      #1 chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));

      // branch beats load-use
      do_reset();
      memRead_EX = 1; RD_EX = 5; RS2_ID = 5; useRS2_ID = 1; branchTaken_EX = 1;
      #1 chk("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
      cyc();
      idle_inputs();
      chk_regs("br_lu", 0, 0, 0, 1);

      // three-cycle memory wait, released on the fourth
      do_reset();
      memReq_MEM = 1; memReady = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("memwait%0d_ctl", i), 32'(ctl), 32'(C_MEMST));
         cyc();
      end
      memReady = 1; branchTaken_EX = 1;
      #1 chk("memwait_release_ctl", 32'(ctl), 32'(C_BRANCH));
      cyc();
      idle_inputs();
      #1 chk("memwait_after_ctl", 32'(ctl), 32'(C_NORMAL));
      chk_regs("memwait", 0, 0, 3, 1);

      // timeout after MAX_WAIT+1 stall cycles
      do_reset();
      memReq_MEM = 1; memReady = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("timeout%0d_halted", i), 32'(halted), 32'(0));
         #1 chk($sformatf("timeout%0d_ctl", i), 32'(ctl), 32'(C_MEMST));
         cyc();
      end
      chk_regs("timeout", 1, 1, 5, 0);
      #1 chk("timeout_halt_ctl", 32'(ctl), 32'(C_FROZEN));
      memReady = 1; branchTaken_EX = 1;
      #1 chk("timeout_ignore_ctl", 32'(ctl), 32'(C_FROZEN));
      cyc();
      chk_regs("timeout_hold", 1, 1, 5, 0);

      // reset out of HALT
      idle_inputs();
      RSTn = 0;
      #1 chk("rst_halt_ctl", 32'(ctl), 32'(C_RESET));
      cyc();
      chk_regs("rst_halt", 0, 0, 0, 0);

      // halt request wins over branch and freezes
      RSTn = 1;
      haltReq_WB = 1; branchTaken_EX = 1;
      #1 chk("halt_ctl", 32'(ctl), 32'(C_FROZEN));
      cyc();
      chk_regs("halt", 1, 0, 1, 0);
      haltReq_WB = 0;
      #1 chk("halt_hold_ctl", 32'(ctl), 32'(C_FROZEN));
      cyc();
      chk_regs("halt_hold", 1, 0, 1, 0);

      // halt request while waiting on memory
      do_reset();
      memReq_MEM = 1;
      #1 chk("wait_halt0_ctl", 32'(ctl), 32'(C_MEMST));
      cyc();
      haltReq_WB = 1;
      #1 chk("wait_halt1_ctl", 32'(ctl), 32'(C_FROZEN));
      cyc();
      chk_regs("wait_halt", 1, 0, 2, 0);

      // flush counter saturates at 7
      do_reset();
      branchTaken_EX = 1;
      for (int i = 0; i < 7; i++) cyc();
      chk("sat7_flushCount", 32'(flushCount), 32'(7));
      cyc();
      cyc();
      chk("sat9_flushCount", 32'(flushCount), 32'(7));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
